imem_port_arbiter: RTL and testbench

Arbitrates the instruction BRAM between the dual-issue fetch path and the program loader, which writes instruction words at boot or under debug. It drives the BRAM address, write-enable and write-data lines and returns the fetched instruction pair with a registered valid flag. Instructions are replaced by NOOP whenever no valid fetch data is present. It sits between the fetch stage, the loader and the dual-port instruction BRAM (port A read/write, port B read-only, 1-cycle read latency).

---
 rtl/imem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Instruction BRAM port arbiter: shares port A between the dual-issue fetch path and
// the program loader, and returns a registered-valid instruction pair (NOOP-filled otherwise).
module imem_port_arbiter #(
    parameter int          ADDR_W      = 11,
    parameter int          DATA_W      = 32,
    parameter int          MAX_BURST   = 16,
    // Opcode field of the NOOP instruction in the ISA opcode table.
    parameter logic [5:0]  NOOP_OPCODE = 6'h15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              fetch_req,
    input  logic [29:0]       fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instr0,
    output logic [DATA_W-1:0] instr1,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic              load_busy,

    output logic [ADDR_W-1:0] bram_addra,
    output logic [ADDR_W-1:0] bram_addrb,
    output logic              bram_wea,
    output logic [DATA_W-1:0] bram_dina,
    input  logic [DATA_W-1:0] bram_douta,
    input  logic [DATA_W-1:0] bram_doutb
);

    localparam int                CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [DATA_W-1:0] NOOP_WORD  = {NOOP_OPCODE, {(DATA_W-6){1'b0}}};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_YIELD = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fetch_valid_q;
    logic [ADDR_W-1:0]  addra_q;
    logic [ADDR_W-1:0]  addra_d;
    logic [DATA_W-1:0]  dina_q;
    logic [DATA_W-1:0]  dina_d;
    logic               unused_fetch_addr_hi;

    // Only the low ADDR_W bits of the fetch word address reach the BRAM.
    assign unused_fetch_addr_hi = ^fetch_addr[29:ADDR_W];

    // Grant: loader has priority except in ST_YIELD, where a pending fetch takes
    // the slot; if no fetch is pending the loader still gets it.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_ack    = 1'b0;
        if (!rst) begin
            if (state_q == ST_YIELD) begin
                if (fetch_req) begin
                    fetch_gnt = 1'b1;
                end else if (ld_req) begin
                    ld_ack = 1'b1;
                end
            end else begin
                if (ld_req) begin
                    ld_ack = 1'b1;
                end else if (fetch_req) begin
                    fetch_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        addra_d = addra_q;
        dina_d  = dina_q;
        if (fetch_gnt) begin
            addra_d = fetch_addr[ADDR_W-1:0];
        end else if (ld_ack) begin
            addra_d = ld_addr;
            dina_d  = ld_data;
        end
    end

    assign bram_addra = addra_d;
    assign bram_addrb = addra_d + ADDR_W'(1);
    assign bram_wea   = ld_ack;
    assign bram_dina  = dina_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            addra_q       <= '0;
            dina_q        <= '0;
        end else begin
            addra_q       <= addra_d;
            dina_q        <= dina_d;
            fetch_valid_q <= fetch_gnt & ~fetch_flush;
            if (ld_ack) begin
                if (cnt_q == BURST_LAST) begin
                    state_q <= ST_YIELD;
                    cnt_q   <= '0;
                end else begin
                    state_q <= ST_LOAD;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
            end else begin
                state_q <= ST_FETCH;
                cnt_q   <= '0;
            end
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign load_busy   = (state_q == ST_LOAD);

    // Two issue lanes share the same NOOP substitution on invalid cycles.
    logic [DATA_W-1:0] lane_dout  [2];
    logic [DATA_W-1:0] lane_instr [2];

    assign lane_dout[0] = bram_douta;
    assign lane_dout[1] = bram_doutb;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_instr[gi] = fetch_valid_q ? lane_dout[gi] : NOOP_WORD;
        end
    endgenerate

    assign instr0 = lane_instr[0];
    assign instr1 = lane_instr[1];

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle-latency dual-port BRAM.
module tb_imem_port_arbiter;

    localparam int          ADDR_W = 11;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOOP   = 32'h5400_0000;
    localparam logic [31:0] VAL_A  = 32'hAAAA_0005;
    localparam logic [31:0] VAL_B  = 32'hBBBB_0006;
    localparam logic [31:0] VAL_C  = 32'hCCCC_07FF;
    localparam logic [31:0] VAL_D  = 32'hDDDD_0000;
    localparam logic [31:0] VAL_E  = 32'hEEEE_012C;

    logic              clk;
    logic              rst;
    logic              fetch_req;
    logic [29:0]       fetch_addr;
    logic              fetch_flush;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] instr0;
    logic [DATA_W-1:0] instr1;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;
    logic              load_busy;
    logic [ADDR_W-1:0] bram_addra;
    logic [ADDR_W-1:0] bram_addrb;
    logic              bram_wea;
    logic [DATA_W-1:0] bram_dina;
    logic [DATA_W-1:0] bram_douta;
    logic [DATA_W-1:0] bram_doutb;

    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] mem [0:2047];

    int checks;
    int errors;

    imem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_flush (fetch_flush),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .instr0      (instr0),
        .instr1      (instr1),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .load_busy   (load_busy),
        .bram_addra  (bram_addra),
        .bram_addrb  (bram_addrb),
        .bram_wea    (bram_wea),
        .bram_dina   (bram_dina),
        .bram_douta  (bram_douta),
        .bram_doutb  (bram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port A read/write, port B read-only; bench preload path takes priority.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bram_wea) begin
            mem[bram_addra] <= bram_dina;
        end
        bram_douta <= mem[bram_addra];
        bram_doutb <= mem[bram_addrb];
    end

    task automatic test_reset();
        logic [ADDR_W-1:0] a_tab [5];
        logic [DATA_W-1:0] d_tab [5];
        a_tab[0] = 11'd5;    d_tab[0] = VAL_A;
        a_tab[1] = 11'd6;    d_tab[1] = VAL_B;
        a_tab[2] = 11'd2047; d_tab[2] = VAL_C;
        a_tab[3] = 11'd0;    d_tab[3] = VAL_D;
        a_tab[4] = 11'd300;  d_tab[4] = VAL_E;
        rst       = 1'b1;
        fetch_req = 1'b1;
        ld_req    = 1'b1;
        ld_addr   = 11'd300;
        ld_data   = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            pre_we   = 1'b1;
            pre_addr = a_tab[i];
            pre_data = d_tab[i];
            #1;
            checks++;
            if ({fetch_gnt, ld_ack, bram_wea, load_busy, fetch_valid} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: gnt/ack/wea/busy/valid got %b expected 00000", i,
                         {fetch_gnt, ld_ack, bram_wea, load_busy, fetch_valid});
            end
            checks++;
            if (instr0 !== NOOP || instr1 !== NOOP) begin
                errors++;
                $display("FAIL reset_noop[%0d]: instr0 %h instr1 %h expected %h", i, instr0, instr1, NOOP);
            end
            @(negedge clk);
        end
        pre_we    = 1'b0;
        rst       = 1'b0;
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_fetch_and_wrap();
        fetch_req  = 1'b1;
        fetch_addr = 30'd5;
        #1;
        checks++;
        if (fetch_gnt !== 1'b1 || ld_ack !== 1'b0 || bram_wea !== 1'b0) begin
            errors++;
            $display("FAIL fetch_grant: gnt %b ack %b wea %b expected 1 0 0", fetch_gnt, ld_ack, bram_wea);
        end
        checks++;
        if (bram_addra !== 11'd5 || bram_addrb !== 11'd6) begin
            errors++;
            $display("FAIL fetch_addr: addra %0d addrb %0d expected 5 6", bram_addra, bram_addrb);
        end
        @(negedge clk);
        fetch_addr = 30'h3FFF_FFFF;
        #1;
        checks++;
        if (fetch_valid !== 1'b1 || instr0 !== VAL_A || instr1 !== VAL_B) begin
            errors++;
            $display("FAIL fetch_data: valid %b instr0 %h instr1 %h expected 1 %h %h",
                     fetch_valid, instr0, instr1, VAL_A, VAL_B);
        end
        checks++;
        if (fetch_gnt !== 1'b1 || bram_addra !== 11'd2047 || bram_addrb !== 11'd0) begin
            errors++;
            $display("FAIL wrap_addr: gnt %b addra %0d addrb %0d expected 1 2047 0",
                     fetch_gnt, bram_addra, bram_addrb);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b1 || instr0 !== VAL_C || instr1 !== VAL_D) begin
            errors++;
            $display("FAIL wrap_data: valid %b instr0 %h instr1 %h expected 1 %h %h",
                     fetch_valid, instr0, instr1, VAL_C, VAL_D);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || instr0 !== NOOP || instr1 !== NOOP) begin
            errors++;
            $display("FAIL idle_noop: valid %b instr0 %h instr1 %h expected 0 %h %h",
                     fetch_valid, instr0, instr1, NOOP, NOOP);
        end
        $display("test_fetch_and_wrap done");
    endtask

    task automatic test_write_then_fetch();
        @(negedge clk);
        ld_req  = 1'b1;
        ld_addr = 11'd9;
        ld_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ld_ack !== 1'b1 || fetch_gnt !== 1'b0 || bram_wea !== 1'b1 ||
            bram_addra !== 11'd9 || bram_dina !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ld_write: ack %b gnt %b wea %b addra %0d dina %h expected 1 0 1 9 deadbeef",
                     ld_ack, fetch_gnt, bram_wea, bram_addra, bram_dina);
        end
        @(negedge clk);
        ld_req     = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 30'd9;
        #1;
        checks++;
        if (fetch_gnt !== 1'b1 || load_busy !== 1'b1) begin
            errors++;
            $display("FAIL raw_grant: gnt %b busy %b expected 1 1", fetch_gnt, load_busy);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b1 || instr0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL raw_data: valid %b instr0 %h expected 1 deadbeef", fetch_valid, instr0);
        end
        $display("test_write_then_fetch done");
    endtask

    task automatic test_flush();
        @(negedge clk);
        fetch_req   = 1'b1;
        fetch_addr  = 30'd5;
        fetch_flush = 1'b1;
        #1;
        checks++;
        if (fetch_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_grant: gnt %b expected 1", fetch_gnt);
        end
        @(negedge clk);
        fetch_flush = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || instr0 !== NOOP || instr1 !== NOOP) begin
            errors++;
            $display("FAIL flush_squash: valid %b instr0 %h instr1 %h expected 0 %h %h",
                     fetch_valid, instr0, instr1, NOOP, NOOP);
        end
        @(negedge clk);
        fetch_req   = 1'b0;
        fetch_flush = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b1 || instr0 !== VAL_A || instr1 !== VAL_B) begin
            errors++;
            $display("FAIL flush_late: valid %b instr0 %h instr1 %h expected 1 %h %h",
                     fetch_valid, instr0, instr1, VAL_A, VAL_B);
        end
        @(negedge clk);
        fetch_flush = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_nogrant: valid %b expected 0", fetch_valid);
        end
        $display("test_flush done");
    endtask

    task automatic test_burst_contention();
        int ph;
        logic exp_ld;
        logic exp_busy;
        logic exp_valid;
        @(negedge clk);
        ld_req     = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 30'd5;
        for (int k = 0; k < 40; k++) begin
            ld_addr = ADDR_W'(400 + k);
            ld_data = 32'(k);
            ph        = k % 17;
            exp_ld    = (ph < 16);
            exp_busy  = (ph >= 1) && (ph <= 15);
            exp_valid = (k > 0) && (((k - 1) % 17) == 16);
            #1;
            checks++;
            if (ld_ack !== exp_ld || fetch_gnt !== ~exp_ld || bram_wea !== exp_ld) begin
                errors++;
                $display("FAIL burst_grant[%0d]: ack %b gnt %b wea %b expected %b %b %b",
                         k, ld_ack, fetch_gnt, bram_wea, exp_ld, ~exp_ld, exp_ld);
            end
            checks++;
            if (load_busy !== exp_busy || fetch_valid !== exp_valid) begin
                errors++;
                $display("FAIL burst_state[%0d]: busy %b valid %b expected %b %b",
                         k, load_busy, fetch_valid, exp_busy, exp_valid);
            end
            @(negedge clk);
        end
        ld_req    = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        $display("test_burst_contention done");
    endtask

    task automatic test_continuous_load();
        ld_req = 1'b1;
        for (int k = 0; k < 34; k++) begin
            ld_addr = ADDR_W'(500 + k);
            ld_data = 32'h1000 + 32'(k);
            #1;
            checks++;
            if (ld_ack !== 1'b1 || fetch_gnt !== 1'b0 || load_busy !== ((k % 16) != 0)) begin
                errors++;
                $display("FAIL cont_load[%0d]: ack %b gnt %b busy %b expected 1 0 %b",
                         k, ld_ack, fetch_gnt, load_busy, ((k % 16) != 0));
            end
            @(negedge clk);
        end
        ld_req = 1'b0;
        @(negedge clk);
        $display("test_continuous_load done");
    endtask

    task automatic test_rst_mid_burst();
        ld_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ld_addr = ADDR_W'(600 + k);
            ld_data = 32'(k);
            @(negedge clk);
        end
        rst       = 1'b1;
        fetch_req = 1'b1;
        ld_addr   = 11'd300;
        ld_data   = 32'h1234_5678;
        #1;
        checks++;
        if (ld_ack !== 1'b0 || bram_wea !== 1'b0 || fetch_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_cycle: ack %b wea %b gnt %b expected 0 0 0", ld_ack, bram_wea, fetch_gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (load_busy !== 1'b0 || fetch_valid !== 1'b0 || mem[300] !== VAL_E) begin
            errors++;
            $display("FAIL rst_after: busy %b valid %b mem300 %h expected 0 0 %h",
                     load_busy, fetch_valid, mem[300], VAL_E);
        end
        for (int k = 0; k < 17; k++) begin
            ld_addr = ADDR_W'(700 + k);
            #1;
            checks++;
            if (ld_ack !== (k < 16) || fetch_gnt !== (k == 16)) begin
                errors++;
                $display("FAIL rst_reburst[%0d]: ack %b gnt %b expected %b %b",
                         k, ld_ack, fetch_gnt, (k < 16), (k == 16));
            end
            @(negedge clk);
        end
        ld_req    = 1'b0;
        fetch_req = 1'b0;
        $display("test_rst_mid_burst done");
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_flush = 1'b0;
        ld_req      = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        @(negedge clk);
        test_reset();
        test_fetch_and_wrap();
        test_write_then_fetch();
        test_flush();
        test_burst_contention();
        test_continuous_load();
        test_rst_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
